// File: rtl/alu_pkg.sv
// Shared opcode map and flag layout for the pipelined ALU and its combinational core.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam int FLAG_C    = 0;
  localparam int FLAG_V    = 1;
  localparam int FLAG_Z    = 2;
  localparam int NUM_FLAGS = 3;

  typedef logic [NUM_FLAGS-1:0] alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: arithmetic with carry-in, logic ops, unsigned compare and
// barrel shifts by B[SHW-1:0]; produces result plus carry, signed-overflow and zero flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       sel_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [SHW-1:0]     amt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] shl_ext;
  logic [2*WIDTH-1:0] shr_ext;

  assign amt  = b_i[SHW-1:0];
  assign sum  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
  // Bit WIDTH of the difference is the borrow; it is set exactly when A < B + CIN.
  assign diff = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_i};

  // Shifting through a double-width window leaves the last bit shifted out next to the
  // result (and a zero there for amount 0), so no special cases are needed, even when
  // WIDTH is not a power of two and the amount can exceed WIDTH.
  assign shl_ext = {{WIDTH{1'b0}}, a_i} << amt;
  assign shr_ext = {a_i, {WIDTH{1'b0}}} >> amt;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    unique case (sel_i)
      OP_ADD: begin
        result_o   = sum[MSB:0];
        carry_o    = sum[WIDTH];
        overflow_o = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        result_o   = diff[MSB:0];
        carry_o    = ~diff[WIDTH];
        overflow_o = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_CMP: result_o = {{(WIDTH-1){1'b0}}, (a_i > b_i)};
      OP_SHL: begin
        result_o = shl_ext[MSB:0];
        carry_o  = shl_ext[WIDTH];
      end
      OP_SHR: begin
        result_o = shr_ext[2*WIDTH-1:WIDTH];
        carry_o  = shr_ext[MSB];
      end
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU (operand capture, then result/flags) with valid/ready on both
// sides, fixed 2-cycle latency and full backpressure.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       SEL,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             OVERFLOW,
  output logic             ZERO
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [2:0]       s1_sel_q,   s1_sel_d;
  logic             s1_cin_q,   s1_cin_d;

  logic             s2_valid_q,  s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  alu_flags_t       s2_flags_q,  s2_flags_d;

  logic             s2_load;
  logic             in_fire;
  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_overflow;
  logic             core_zero;

  // S2 may take a new value whenever its current beat is absent or leaving; S1 drains
  // into S2 on the same condition, so IN_READY never depends on IN_VALID.
  assign s2_load  = !s2_valid_q || OUT_READY;
  assign IN_READY = !s1_valid_q || s2_load;
  assign in_fire  = IN_VALID && IN_READY;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i       (s1_a_q),
    .b_i       (s1_b_q),
    .sel_i     (s1_sel_q),
    .cin_i     (s1_cin_q),
    .result_o  (core_result),
    .carry_o   (core_carry),
    .overflow_o(core_overflow),
    .zero_o    (core_zero)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sel_d   = s1_sel_q;
    s1_cin_d   = s1_cin_q;
    if (IN_READY) begin
      s1_valid_d = IN_VALID;
    end
    if (in_fire) begin
      s1_a_d   = A;
      s1_b_d   = B;
      s1_sel_d = SEL;
      s1_cin_d = CIN;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      // Result/flags only change when a real beat arrives, keeping the outputs quiet on bubbles.
      if (s1_valid_q) begin
        s2_result_d           = core_result;
        s2_flags_d[FLAG_C]    = core_carry;
        s2_flags_d[FLAG_V]    = core_overflow;
        s2_flags_d[FLAG_Z]    = core_zero;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: datapath registers are reset along with the valids so RESULT and the flags
      // read zero during and straight after reset, not whatever was in flight.
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sel_q    <= OP_ADD;
      s1_cin_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_sel_q    <= s1_sel_d;
      s1_cin_q    <= s1_cin_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
    end
  end

  assign OUT_VALID = s2_valid_q;
  assign RESULT    = s2_result_q;
  assign CARRY     = s2_flags_q[FLAG_C];
  assign OVERFLOW  = s2_flags_q[FLAG_V];
  assign ZERO      = s2_flags_q[FLAG_Z];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: hand-computed 8-bit vectors, backpressure stream, reset
// mid-stall, and an exhaustive WIDTH=4 sweep against a small reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, carry8, ovf8, zero8;
  logic [7:0] a8, b8, res8;
  logic [2:0] sel8;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, cin4, carry4, ovf4, zero4;
  logic [3:0] a4, b4, res4;
  logic [2:0] sel4;

  int n_cmp = 0;
  int n_err = 0;

  alu_pipe #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid8), .IN_READY(in_ready8),
    .A(a8), .B(b8), .SEL(sel8), .CIN(cin8), .OUT_VALID(out_valid8), .OUT_READY(out_ready8),
    .RESULT(res8), .CARRY(carry8), .OVERFLOW(ovf8), .ZERO(zero8)
  );

  alu_pipe #(.WIDTH(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid4), .IN_READY(in_ready4),
    .A(a4), .B(b4), .SEL(sel4), .CIN(cin4), .OUT_VALID(out_valid4), .OUT_READY(out_ready4),
    .RESULT(res4), .CARRY(carry4), .OVERFLOW(ovf4), .ZERO(zero4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic sign_of(input int x, input int w);
    return ((x >> (w - 1)) & 1) != 0;
  endfunction

  // Reference behaviour written from the opcode definitions in integer arithmetic.
  function automatic void model(input int w, input logic [2:0] sel, input int a, input int b,
                                input logic cin, output int r, output logic c, output logic v);
    int mask, amt, s;
    mask = (1 << w) - 1;
    amt  = b & ((1 << $clog2(w)) - 1);
    r = 0; c = 1'b0; v = 1'b0;
    case (sel)
      OP_ADD: begin
        s = a + b + int'(cin);
        r = s & mask;
        c = ((s >> w) & 1) != 0;
        v = (sign_of(a, w) == sign_of(b, w)) && (sign_of(r, w) != sign_of(a, w));
      end
      OP_SUB: begin
        s = a - b - int'(cin);
        r = s & mask;
        c = a >= b + int'(cin);
        v = (sign_of(a, w) != sign_of(b, w)) && (sign_of(r, w) != sign_of(a, w));
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_CMP: r = (a > b) ? 1 : 0;
      OP_SHL: begin
        r = (a << amt) & mask;
        c = (amt != 0) && (amt <= w) && (((a >> (w - amt)) & 1) != 0);
      end
      default: begin
        r = a >> amt;
        c = (amt != 0) && (((a >> (amt - 1)) & 1) != 0);
      end
    endcase
  endfunction

  // One beat through dut8 with OUT_READY high; lat counts falling edges after acceptance.
  task automatic op8(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, output logic [10:0] outs, output int lat);
    int guard;
    @(negedge clk);
    sel8 = sel; a8 = a; b8 = b; cin8 = cin; in_valid8 = 1'b1; out_ready8 = 1'b1;
    guard = 0;
    while (!in_ready8 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid8 && lat < 10);
    outs = {res8, carry8, ovf8, zero8};
  endtask

  task automatic op4(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b,
                     input logic cin, output logic [6:0] outs, output int lat);
    int guard;
    @(negedge clk);
    sel4 = sel; a4 = a; b4 = b; cin4 = cin; in_valid4 = 1'b1; out_ready4 = 1'b1;
    guard = 0;
    while (!in_ready4 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid4 && lat < 10);
    outs = {res4, carry4, ovf4, zero4};
  endtask

  typedef struct {
    string      tag;
    logic [2:0] sel;
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] r;
    logic       c, v, z;
  } vec8_t;

  vec8_t vecs[18] = '{
    '{"add_ovf",    OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0},
    '{"sub_equal",  OP_SUB, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1},
    '{"sub_borrow", OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0},
    '{"shl_1",      OP_SHL, 8'h81, 8'h01, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0},
    '{"shr_3",      OP_SHR, 8'h81, 8'h03, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0},
    '{"shl_amt0",   OP_SHL, 8'h5A, 8'h08, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0},
    '{"shr_amt0",   OP_SHR, 8'hA5, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0},
    '{"add_cin",    OP_ADD, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1},
    '{"sub_cin",    OP_SUB, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1},
    '{"sub_ovf",    OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0},
    '{"cmp_gt",     OP_CMP, 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0},
    '{"cmp_eq",     OP_CMP, 8'h33, 8'h33, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1},
    '{"and",        OP_AND, 8'hFF, 8'h0F, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0},
    '{"or",         OP_OR,  8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0},
    '{"xor_zero",   OP_XOR, 8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1},
    '{"shr_7",      OP_SHR, 8'hC0, 8'h07, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0},
    '{"shl_7",      OP_SHL, 8'h03, 8'h07, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0},
    '{"add_plain",  OP_ADD, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0}
  };

  logic [2:0] bp_sel[8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_SHL, OP_SHR};
  logic [7:0] bp_a[8]   = '{8'hC8, 8'h3C, 8'h5F, 8'h90, 8'h77, 8'h41, 8'hB3, 8'hE6};
  logic [7:0] bp_b[8]   = '{8'h9D, 8'h7E, 8'hF1, 8'h06, 8'h77, 8'h40, 8'h05, 8'h0A};
  logic       bp_cin[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [10:0] outs8;
    logic [6:0]  outs4;
    logic [10:0] held;
    logic        held_valid;
    logic [15:0] rdy_pat;
    logic [10:0] sb8[$];
    logic [6:0]  sb4[$];
    logic [10:0] exp8;
    logic [6:0]  exp4;
    int lat, sent, got, r;
    logic c, v;

    rst_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; sel8 = '0; cin8 = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; sel4 = '0; cin4 = 1'b0;

    #2;
    check("rst_out_valid", out_valid8, 1'b0);
    check("rst_outputs", {res8, carry8, ovf8, zero8}, 11'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready8, 1'b1);

    // Directed 8-bit vectors, each with its latency.
    foreach (vecs[i]) begin
      op8(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, outs8, lat);
      check({vecs[i].tag, "_lat"}, lat, 2);
      check({vecs[i].tag, "_result"}, outs8[10:3], vecs[i].r);
      check({vecs[i].tag, "_flags_cvz"}, outs8[2:0], {vecs[i].c, vecs[i].v, vecs[i].z});
    end

    // Backpressure: 8 back-to-back beats with a pseudo-random OUT_READY pattern.
    rdy_pat = 16'b1011_0010_1100_0110;
    sent = 0; got = 0; held_valid = 1'b0; held = '0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready8 = rdy_pat[cyc % 16];
      if (sent < 8) begin
        sel8 = bp_sel[sent]; a8 = bp_a[sent]; b8 = bp_b[sent]; cin8 = bp_cin[sent];
        in_valid8 = 1'b1;
      end else begin
        in_valid8 = 1'b0;
      end
      #1;
      check("bp_in_ready", in_ready8, (sent - got < 2) || out_ready8);
      if (held_valid) begin
        check("bp_stall_valid", out_valid8, 1'b1);
        check("bp_stall_hold", {res8, carry8, ovf8, zero8}, held);
      end
      held_valid = 1'b0;
      if (out_valid8) begin
        if (sb8.size() == 0) begin
          check("bp_spurious_valid", out_valid8, 1'b0);
        end else if (out_ready8) begin
          exp8 = sb8.pop_front();
          check("bp_result", {res8, carry8, ovf8, zero8}, exp8);
          got++;
        end else begin
          held_valid = 1'b1;
          held = {res8, carry8, ovf8, zero8};
        end
      end
      if (in_valid8 && in_ready8) begin
        model(8, sel8, int'(a8), int'(b8), cin8, r, c, v);
        sb8.push_back({8'(r), c, v, (r == 0)});
        sent++;
      end
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    check("bp_count", got, 8);

    // Reset while two beats are stalled in the pipe.
    out_ready8 = 1'b0;
    sel8 = OP_ADD; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    sel8 = OP_SUB; a8 = 8'h05; b8 = 8'h05;
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    check("stall_in_ready", in_ready8, 1'b0);
    check("stall_out_valid", out_valid8, 1'b1);
    check("stall_head", {res8, carry8, ovf8, zero8}, {8'h80, 3'b010});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid8, 1'b0);
    check("async_rst_outputs", {res8, carry8, ovf8, zero8}, 11'h0);
    check("async_rst_in_ready", in_ready8, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", out_valid8, 1'b0);
    end

    // WIDTH=4 directed vectors.
    op4(OP_ADD, 4'b0011, 4'b0001, 1'b0, outs4, lat);
    check("w4_add_lat", lat, 2);
    check("w4_add", outs4, {4'b0100, 3'b000});
    op4(OP_CMP, 4'b0100, 4'b0011, 1'b0, outs4, lat);
    check("w4_cmp", outs4, {4'b0001, 3'b000});
    op4(OP_SHL, 4'b1001, 4'b0101, 1'b0, outs4, lat);
    check("w4_shl_wrap_amt", outs4, {4'b0010, 3'b100});

    // WIDTH=4 exhaustive sweep at full throughput.
    out_ready4 = 1'b1;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 5000 && got < 4096; cyc++) begin
      @(negedge clk);
      if (sent < 4096) begin
        sel4 = 3'(sent >> 9); a4 = 4'(sent >> 5); b4 = 4'(sent >> 1); cin4 = 1'(sent);
        in_valid4 = 1'b1;
      end else begin
        in_valid4 = 1'b0;
      end
      #1;
      if (out_valid4) begin
        if (sb4.size() == 0) begin
          check("ex4_spurious_valid", out_valid4, 1'b0);
        end else begin
          exp4 = sb4.pop_front();
          check("ex4", {res4, carry4, ovf4, zero4}, exp4);
          got++;
        end
      end
      if (in_valid4 && in_ready4) begin
        model(4, sel4, int'(a4), int'(b4), cin4, r, c, v);
        sb4.push_back({4'(r), c, v, (r == 0)});
        sent++;
      end
    end
    in_valid4 = 1'b0;
    check("ex4_count", got, 4096);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
